// File: rtl/cpu.sv
// Single-cycle word-addressed mini-MIPS core with host-loaded instruction and
// data memories, a 32x32 register file and a sticky halt flag.
module cpu #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_data,
    input  logic [9:0]  address,
    input  logic        write_instruction,
    input  logic        write_data,
    output logic [31:0] OutputOfR1,
    output logic [31:0] OutputOfR2,
    output logic [31:0] OutputOfR3,
    output logic [31:0] OutputOfR4,
    output logic [31:0] OutputOfR5,
    output logic        done
);

    typedef enum logic [5:0] {
        OP_HALT = 6'b000000,
        OP_ADDI = 6'b000001,
        OP_LW   = 6'b000111,
        OP_SW   = 6'b001000,
        OP_BEQ  = 6'b010000,
        OP_BGE  = 6'b010101
    } opcode_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] regs [32];

    state_t      state;
    state_t      next_state;
    logic [9:0]  pc;
    logic [9:0]  pc_next;

    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [9:0]  eff_index;
    logic [9:0]  pc_plus1;
    logic [9:0]  branch_target;

    logic        reg_we;
    logic [31:0] reg_wdata;
    logic        dmem_we;

    // Instruction fields, operand reads and address arithmetic; $0 always reads zero
    always_comb begin
        instr         = imem[pc];
        op            = instr[31:26];
        ra            = instr[25:21];
        rb            = instr[20:16];
        imm           = instr[15:0];
        simm          = {{16{imm[15]}}, imm};
        a_val         = (ra == 5'd0) ? 32'd0 : regs[ra];
        b_val         = (rb == 5'd0) ? 32'd0 : regs[rb];
        eff_index     = b_val[9:0] + imm[9:0];
        pc_plus1      = pc + 10'd1;
        branch_target = pc_plus1 + imm[9:0];
    end

    // Run/halted state register together with the program counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= 10'd0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Decode: next state, next PC and write strobes; nothing moves once halted
    always_comb begin
        next_state = state;
        pc_next    = pc;
        reg_we     = 1'b0;
        reg_wdata  = 32'd0;
        dmem_we    = 1'b0;
        if (state == ST_RUN) begin
            pc_next = pc_plus1;
            case (op)
                OP_ADDI: begin
                    reg_we    = 1'b1;
                    reg_wdata = b_val + simm;
                end
                OP_LW: begin
                    reg_we    = 1'b1;
                    reg_wdata = dmem[eff_index];
                end
                OP_SW: begin
                    dmem_we = 1'b1;
                end
                OP_BEQ: begin
                    if (a_val == b_val) begin
                        pc_next = branch_target;
                    end
                end
                OP_BGE: begin
                    if ($signed(a_val) >= $signed(b_val)) begin
                        pc_next = branch_target;
                    end
                end
                default: begin
                    if (instr == 32'd0) begin
                        next_state = ST_HALTED;
                        pc_next    = pc;
                    end
                end
            endcase
        end
    end

    // Register file: cleared by reset, writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (reg_we && (ra != 5'd0)) begin
            regs[ra] <= reg_wdata;
        end
    end

    // Instruction memory is only writable by the host while in reset
    always_ff @(posedge clk) begin
        if (rst && write_instruction) begin
            imem[address] <= inst_data;
        end
    end

    // Data memory: host port during reset, store instructions while running
    always_ff @(posedge clk) begin
        if (rst) begin
            if (write_data) begin
                dmem[address] <= inst_data;
            end
        end else if (dmem_we) begin
            dmem[eff_index] <= a_val;
        end
    end

    // Observation ports
    always_comb begin
        OutputOfR1 = regs[1];
        OutputOfR2 = regs[2];
        OutputOfR3 = regs[3];
        OutputOfR4 = regs[4];
        OutputOfR5 = regs[5];
        done       = (state == ST_HALTED);
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the cpu: loads small programs through the host port and
// checks the exported registers and the done flag against hand-computed values.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_data = 32'd0;
    logic [9:0]  address = 10'd0;
    logic        write_instruction = 1'b0;
    logic        write_data = 1'b0;
    logic [31:0] r1, r2, r3, r4, r5;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cycles;

    localparam logic [5:0] ADDI = 6'd1;
    localparam logic [5:0] LW   = 6'd7;
    localparam logic [5:0] SW   = 6'd8;
    localparam logic [5:0] BEQ  = 6'd16;
    localparam logic [5:0] BGE  = 6'd21;
    localparam logic [31:0] HALT = 32'd0;
    localparam logic [31:0] NOP  = 32'hFC00_0000;

    cpu dut (
        .clk               (clk),
        .rst               (rst),
        .inst_data         (inst_data),
        .address           (address),
        .write_instruction (write_instruction),
        .write_data        (write_data),
        .OutputOfR1        (r1),
        .OutputOfR2        (r2),
        .OutputOfR3        (r3),
        .OutputOfR4        (r4),
        .OutputOfR5        (r5),
        .done              (done)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One host write on one edge; is_instr selects imem versus dmem
    task automatic applyStimulus(input logic is_instr, input int addr, input logic [31:0] word);
        address           = addr[9:0];
        inst_data         = word;
        write_instruction = is_instr;
        write_data        = ~is_instr;
        @(posedge clk);
        #1;
        write_instruction = 1'b0;
        write_data        = 1'b0;
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_program(input int max_cycles, output int n);
        rst = 1'b0;
        n   = 0;
        while (n < max_cycles && done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
        checkOutput({tag, "_r1"}, r1, e1);
        checkOutput({tag, "_r2"}, r2, e2);
        checkOutput({tag, "_r3"}, r3, e3);
        checkOutput({tag, "_r4"}, r4, e4);
        checkOutput({tag, "_r5"}, r5, e5);
    endtask

    initial begin
        // Reset, data preload and ADDI program
        enter_reset();
        applyStimulus(1'b0, 0, 32'd7);
        applyStimulus(1'b0, 1, 32'd12);
        applyStimulus(1'b0, 2, 32'd9);
        applyStimulus(1'b0, 3, 32'd11);
        applyStimulus(1'b0, 4, 32'd3);
        applyStimulus(1'b1, 0, enc(ADDI, 1, 0, 16'd5));
        applyStimulus(1'b1, 1, enc(ADDI, 2, 1, 16'hFFFF));
        applyStimulus(1'b1, 2, enc(ADDI, 3, 0, 16'hFFFF));
        applyStimulus(1'b1, 3, HALT);
        check_regs("reset0", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("reset0_done", {31'd0, done}, 32'd0);
        run_program(20, cycles);
        checkOutput("addi_cycles", cycles, 32'd4);
        checkOutput("addi_done", {31'd0, done}, 32'd1);
        check_regs("addi", 32'd5, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_regs("addi_hold", 32'd5, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'd0);
        checkOutput("addi_hold_done", {31'd0, done}, 32'd1);

        // LW/SW round trip through dmem[7]
        enter_reset();
        check_regs("reset1", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("reset1_done", {31'd0, done}, 32'd0);
        applyStimulus(1'b1, 0, enc(ADDI, 1, 0, 16'd42));
        applyStimulus(1'b1, 1, enc(SW, 1, 0, 16'd7));
        applyStimulus(1'b1, 2, enc(LW, 2, 0, 16'd7));
        applyStimulus(1'b1, 3, HALT);
        run_program(20, cycles);
        checkOutput("lwsw_done", {31'd0, done}, 32'd1);
        check_regs("lwsw", 32'd42, 32'd42, 32'd0, 32'd0, 32'd0);

        // Branches: BEQ not taken at 1, BGE equal taken 9->3, BEQ taken 4->15
        enter_reset();
        applyStimulus(1'b1, 0, enc(ADDI, 4, 0, 16'd2));
        applyStimulus(1'b1, 1, enc(BEQ, 4, 0, 16'd1));
        applyStimulus(1'b1, 2, enc(ADDI, 2, 2, 16'd7));
        applyStimulus(1'b1, 3, enc(ADDI, 3, 3, 16'd1));
        applyStimulus(1'b1, 4, enc(BEQ, 3, 4, 16'd10));
        applyStimulus(1'b1, 5, enc(ADDI, 1, 1, 16'd100));
        applyStimulus(1'b1, 6, NOP);
        applyStimulus(1'b1, 7, NOP);
        applyStimulus(1'b1, 8, NOP);
        applyStimulus(1'b1, 9, enc(BGE, 3, 3, 16'hFFF9));
        applyStimulus(1'b1, 10, enc(ADDI, 5, 0, 16'd99));
        applyStimulus(1'b1, 11, HALT);
        applyStimulus(1'b1, 15, enc(ADDI, 5, 0, 16'd55));
        applyStimulus(1'b1, 16, HALT);
        run_program(40, cycles);
        checkOutput("branch_cycles", cycles, 32'd14);
        check_regs("branch", 32'd100, 32'd7, 32'd2, 32'd2, 32'd55);

        // Insertion sort of dmem[0..4]
        enter_reset();
        applyStimulus(1'b1, 0, enc(ADDI, 1, 0, 16'd0));
        applyStimulus(1'b1, 1, enc(ADDI, 31, 0, 16'd5));
        applyStimulus(1'b1, 2, enc(ADDI, 1, 0, 16'd0));
        applyStimulus(1'b1, 3, enc(ADDI, 1, 1, 16'd1));
        applyStimulus(1'b1, 4, enc(BEQ, 1, 31, 16'd10));
        applyStimulus(1'b1, 5, enc(ADDI, 2, 1, 16'hFFFF));
        applyStimulus(1'b1, 6, enc(ADDI, 5, 2, 16'd1));
        applyStimulus(1'b1, 7, enc(LW, 7, 2, 16'd0));
        applyStimulus(1'b1, 8, enc(LW, 8, 5, 16'd0));
        applyStimulus(1'b1, 9, enc(BGE, 8, 7, 16'hFFF9));
        applyStimulus(1'b1, 10, enc(SW, 7, 5, 16'd0));
        applyStimulus(1'b1, 11, enc(SW, 8, 2, 16'd0));
        applyStimulus(1'b1, 12, enc(BEQ, 2, 0, 16'hFFF6));
        applyStimulus(1'b1, 13, enc(ADDI, 2, 2, 16'hFFFF));
        applyStimulus(1'b1, 14, enc(BEQ, 0, 0, 16'hFFF7));
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 15 + k, enc(LW, 5'(k + 1), 0, 16'(k)));
        end
        applyStimulus(1'b1, 20, HALT);
        run_program(150, cycles);
        checkOutput("sort_done", {31'd0, done}, 32'd1);
        check_regs("sort", 32'd3, 32'd7, 32'd9, 32'd11, 32'd12);

        // $0 protection, then a host write attempt while not in reset
        enter_reset();
        applyStimulus(1'b1, 0, enc(ADDI, 0, 0, 16'd9));
        applyStimulus(1'b1, 1, enc(ADDI, 1, 0, 16'd0));
        applyStimulus(1'b1, 2, enc(LW, 2, 0, 16'd0));
        applyStimulus(1'b1, 3, HALT);
        run_program(20, cycles);
        checkOutput("zero_done", {31'd0, done}, 32'd1);
        check_regs("zero", 32'd0, 32'd3, 32'd0, 32'd0, 32'd0);
        applyStimulus(1'b0, 0, 32'd999);
        enter_reset();
        run_program(20, cycles);
        checkOutput("gate_done", {31'd0, done}, 32'd1);
        checkOutput("gate_dmem0", r2, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
